// File: rtl/conv_frame_sequencer.sv
// Frame-level flow controller: counts pixels into rows, gates the upstream
// stream on line-buffer credit and output-FIFO watermark, counts convolved
// outputs and pulses frame_done once the full frame has been produced.
module conv_frame_sequencer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int LB_LINES   = 4
) (
  input  logic                          top_clk,
  input  logic                          top_rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          in_data_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_data_ready,
  output logic                          lb_data_valid,
  output logic [7:0]                    lb_data,
  input  logic                          lb_line_consumed,
  input  logic                          fifo_prog_full,
  input  logic                          conv_data_valid,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(IMG_HEIGHT+1)-1:0] row_count,
  output logic                          err_underflow
);

  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT + 1);
  localparam int LB_W      = $clog2(LB_LINES + 1);
  localparam int OUT_TOTAL = (IMG_HEIGHT - 2) * IMG_WIDTH;
  localparam int OUT_W     = $clog2(OUT_TOTAL + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IMG_HEIGHT);
  localparam logic [LB_W-1:0]  LB_MAX   = LB_W'(LB_LINES);
  localparam logic [LB_W-1:0]  LB_PRIME = LB_W'(LB_LINES - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(OUT_TOTAL);

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, DRAIN, DONE} state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] rows_in;
  logic [LB_W-1:0]  lines_buf;
  logic [OUT_W-1:0] out_cnt;

  logic accepting;
  logic acc;
  logic wrap;
  logic last_pix;
  logic abort_hit;
  logic start_hit;
  logic count_outs;

  // Ready depends only on registered state/counters plus the FIFO watermark,
  // so there is no combinational path from in_data_valid back to ready.
  assign accepting     = (state == PRIME) || (state == STREAM);
  assign in_data_ready = accepting && (lines_buf < LB_MAX) && !fifo_prog_full &&
                         (rows_in < ROW_MAX);
  assign acc           = in_data_valid && in_data_ready;
  assign wrap          = acc && (col == COL_LAST);
  assign last_pix      = wrap && (rows_in == ROW_LAST);
  assign abort_hit     = abort && (state != IDLE);
  assign start_hit     = start && (state == IDLE);
  assign count_outs    = accepting || (state == DRAIN);
  assign row_count     = rows_in;

  // Frame FSM with registered busy/frame_done; abort overrides every transition.
  always_ff @(posedge top_clk or negedge top_rst) begin
    if (!top_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort_hit) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= PRIME;
              busy  <= 1'b1;
            end
          end
          PRIME: begin
            // A very short frame can finish entering before priming completes.
            if (last_pix)                    state <= DRAIN;
            else if (lines_buf >= LB_PRIME)  state <= STREAM;
          end
          STREAM: begin
            if (last_pix) state <= DRAIN;
          end
          DRAIN: begin
            if (out_cnt == OUT_MAX) begin
              state      <= DONE;
              frame_done <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Position, line-credit and output counters; abort clears all but the sticky error.
  always_ff @(posedge top_clk or negedge top_rst) begin
    if (!top_rst) begin
      col           <= '0;
      rows_in       <= '0;
      lines_buf     <= '0;
      out_cnt       <= '0;
      err_underflow <= 1'b0;
    end else if (abort_hit) begin
      col       <= '0;
      rows_in   <= '0;
      lines_buf <= '0;
      out_cnt   <= '0;
    end else begin
      if (start_hit) begin
        col     <= '0;
        rows_in <= '0;
        out_cnt <= '0;
      end else begin
        if (acc) begin
          col <= wrap ? '0 : col + 1'b1;
          if (wrap) rows_in <= rows_in + 1'b1;
        end
        if (count_outs && conv_data_valid && (out_cnt != OUT_MAX))
          out_cnt <= out_cnt + 1'b1;
      end
      // A line completing and a line being freed in the same cycle cancel out.
      if (wrap && !lb_line_consumed) begin
        lines_buf <= lines_buf + 1'b1;
      end else if (!wrap && lb_line_consumed) begin
        if (lines_buf == '0) err_underflow <= 1'b1;
        else                 lines_buf     <= lines_buf - 1'b1;
      end
    end
  end

  // One-cycle registered forwarding to the line-buffer control unit.
  always_ff @(posedge top_clk or negedge top_rst) begin
    if (!top_rst) begin
      lb_data_valid <= 1'b0;
      lb_data       <= '0;
    end else begin
      lb_data_valid <= acc;
      if (acc) lb_data <= in_data;
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer (W=8, H=6, 4 line buffers).
module tb_conv_frame_sequencer;

  localparam int W      = 8;
  localparam int H      = 6;
  localparam int LB     = 4;
  localparam int TARGET = (H - 2) * W;

  logic       top_clk = 1'b0;
  logic       top_rst;
  logic       start, abort, in_data_valid, lb_line_consumed, fifo_prog_full, conv_data_valid;
  logic [7:0] in_data;
  logic       in_data_ready, lb_data_valid, busy, frame_done, err_underflow;
  logic [7:0] lb_data;
  logic [$clog2(H+1)-1:0] row_count;

  conv_frame_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .LB_LINES(LB)) dut (
    .top_clk(top_clk), .top_rst(top_rst), .start(start), .abort(abort),
    .in_data_valid(in_data_valid), .in_data(in_data), .in_data_ready(in_data_ready),
    .lb_data_valid(lb_data_valid), .lb_data(lb_data), .lb_line_consumed(lb_line_consumed),
    .fifo_prog_full(fifo_prog_full), .conv_data_valid(conv_data_valid), .busy(busy),
    .frame_done(frame_done), .row_count(row_count), .err_underflow(err_underflow)
  );

  always #5 top_clk = ~top_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a frame is described by how many pixels and outputs it has
  // seen, how many lines sit in the line buffers, and where it is in its
  // completion timeline (all pixels in, then done pulse, then idle).
  bit         m_active, m_all_in, m_done, m_err, m_lbv;
  logic [7:0] m_lbd;
  int         m_pix, m_lines, m_outs;

  // Values sampled from the DUT at the last checked negedge (for stimulus only).
  bit         acc_seen, done_seen, lbv_seen;
  logic [7:0] lbd_seen;

  typedef struct {
    bit start, abort, valid; logic [7:0] data; bit cons, pf, conv;
    bit e_ready, e_busy, e_done, e_lbv; logic [7:0] e_lbd; bit e_err; int e_row;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(bit s, bit a, bit v, logic [7:0] d, bit c, bit p, bit cv,
                              bit er, bit eb, bit ed, bit el, logic [7:0] eld, bit ee, int erow);
    vec_t t;
    t.start = s; t.abort = a; t.valid = v; t.data = d; t.cons = c; t.pf = p; t.conv = cv;
    t.e_ready = er; t.e_busy = eb; t.e_done = ed; t.e_lbv = el; t.e_lbd = eld;
    t.e_err = ee; t.e_row = erow;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return m_active && !m_done && (m_lines < LB) && !fifo_prog_full && (m_pix < W * H);
  endfunction

  task automatic model_reset();
    m_active = 0; m_all_in = 0; m_done = 0; m_err = 0; m_lbv = 0; m_lbd = '0;
    m_pix = 0; m_lines = 0; m_outs = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit acc, wrap;
    int outs_old;
    acc      = in_data_valid && exp_ready();
    wrap     = acc && ((m_pix % W) == W - 1);
    outs_old = m_outs;
    m_lbv    = acc;
    if (acc) m_lbd = in_data;
    if (m_active && abort) begin
      m_active = 0; m_all_in = 0; m_done = 0; m_pix = 0; m_lines = 0; m_outs = 0;
    end else begin
      if (wrap && !lb_line_consumed) m_lines++;
      else if (!wrap && lb_line_consumed) begin
        if (m_lines == 0) m_err = 1;
        else m_lines--;
      end
      if (!m_active) begin
        if (start) begin m_active = 1; m_pix = 0; m_outs = 0; end
      end else begin
        if (conv_data_valid && !m_done && m_outs < TARGET) m_outs++;
        if (acc) m_pix++;
        if (m_done) begin
          m_active = 0; m_done = 0; m_all_in = 0;
        end else if (m_all_in) begin
          if (outs_old == TARGET) m_done = 1;
        end else if (m_pix == W * H) begin
          m_all_in = 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("ready", in_data_ready, exp_ready());
    chk("busy", busy, m_active);
    chk("frame_done", frame_done, m_done);
    chk("row_count", row_count, m_pix / W);
    chk("err_underflow", err_underflow, m_err);
    chk("lb_data_valid", lb_data_valid, m_lbv);
    if (m_lbv) chk("lb_data", lb_data, m_lbd);
  endtask

  task automatic clear_inputs();
    start = 0; abort = 0; in_data_valid = 0; in_data = '0;
    lb_line_consumed = 0; fifo_prog_full = 0; conv_data_valid = 0;
  endtask

  task automatic cycle();
    @(negedge top_clk);
    check_model();
    acc_seen  = in_data_valid && in_data_ready;
    done_seen = frame_done;
    lbv_seen  = lb_data_valid;
    lbd_seen  = lb_data;
    model_edge();
    @(posedge top_clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    top_rst = 1'b0;
    model_reset();
    @(negedge top_clk);
    top_rst = 1'b1;
    @(posedge top_clk);
    #1;
  endtask

  // Drive one frame with a steady pixel stream, a consume every 8 cycles once
  // three lines are buffered, and up to max_conv output pulses; optionally
  // abort once every pixel is in and max_conv outputs have been counted.
  task automatic run_frame(input int max_conv, input bit do_abort, output int dones);
    int  conv_given, cons_given;
    bit  finished;
    dones = 0; conv_given = 0; cons_given = 0; finished = 0;
    start = 1; cycle(); start = 0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      in_data_valid    = 1;
      in_data          = 8'($urandom);
      lb_line_consumed = (m_pix / W >= 3) && (cyc % 8 == 7) && (cons_given < H);
      if (lb_line_consumed) cons_given++;
      conv_data_valid  = (m_pix / W >= 3) && (conv_given < max_conv);
      if (conv_data_valid) conv_given++;
      abort = do_abort && m_all_in && (m_outs == max_conv);
      cycle();
      if (done_seen) dones++;
      if (abort) finished = 1;
      if (!do_abort && dones > 0 && !m_active) finished = 1;
    end
    clear_inputs();
    if (!finished) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int d, acc_total, stalls, next_pix;
    logic [7:0] lbq[$];

    tbl[0]  = mk(0,0,0,8'h00,0,0,0, 0,0,0,0,8'h00,0,0);
    tbl[1]  = mk(1,0,1,8'h11,0,0,0, 0,0,0,0,8'h00,0,0);
    tbl[2]  = mk(0,0,1,8'h22,0,0,0, 1,1,0,0,8'h00,0,0);
    tbl[3]  = mk(0,0,1,8'h33,0,1,0, 0,1,0,1,8'h22,0,0);
    tbl[4]  = mk(0,0,0,8'h44,0,0,1, 1,1,0,0,8'h00,0,0);
    tbl[5]  = mk(0,1,0,8'h00,0,0,0, 1,1,0,0,8'h00,0,0);
    tbl[6]  = mk(0,0,0,8'h00,0,0,1, 0,0,0,0,8'h00,0,0);
    tbl[7]  = mk(1,1,0,8'h00,0,0,0, 0,0,0,0,8'h00,0,0);
    tbl[8]  = mk(0,0,1,8'h55,0,0,0, 1,1,0,0,8'h00,0,0);
    tbl[9]  = mk(0,1,0,8'h00,0,0,0, 1,1,0,1,8'h55,0,0);
    tbl[10] = mk(0,0,0,8'h00,1,0,0, 0,0,0,0,8'h00,0,0);
    tbl[11] = mk(0,0,0,8'h00,0,0,0, 0,0,0,0,8'h00,1,0);

    clear_inputs();
    top_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge top_clk);
    @(negedge top_clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_data_ready, 0);
    chk("rst_lbv", lb_data_valid, 0);
    top_rst = 1'b1;
    @(posedge top_clk);
    #1;

    // Table-driven vectors: start/abort priority, stall, forwarding, underflow.
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; in_data_valid = tbl[i].valid;
      in_data = tbl[i].data; lb_line_consumed = tbl[i].cons;
      fifo_prog_full = tbl[i].pf; conv_data_valid = tbl[i].conv;
      @(negedge top_clk);
      chk($sformatf("vec%0d_ready", i), in_data_ready, tbl[i].e_ready);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), frame_done, tbl[i].e_done);
      chk($sformatf("vec%0d_lbv", i), lb_data_valid, tbl[i].e_lbv);
      chk($sformatf("vec%0d_err", i), err_underflow, tbl[i].e_err);
      chk($sformatf("vec%0d_row", i), row_count, tbl[i].e_row);
      if (tbl[i].e_lbv) chk($sformatf("vec%0d_lbd", i), lb_data, tbl[i].e_lbd);
      model_edge();
      @(posedge top_clk);
      #1;
    end
    clear_inputs();

    // Full frame: exactly one done pulse after the last output.
    do_reset();
    run_frame(TARGET, 0, d);
    chk("t2_done_pulses", d, 1);
    chk("t2_idle_after", busy, 0);
    chk("t2_no_underflow", err_underflow, 0);

    // Reset in the middle of streaming, then a clean restart.
    do_reset();
    start = 1; cycle(); start = 0;
    in_data_valid = 1;
    repeat (20) cycle();
    chk("t1_busy_before", busy, 1);
    top_rst = 1'b0;
    #2;
    chk("t1_busy", busy, 0);
    chk("t1_ready", in_data_ready, 0);
    chk("t1_lbv", lb_data_valid, 0);
    chk("t1_row", row_count, 0);
    clear_inputs();
    model_reset();
    @(negedge top_clk);
    top_rst = 1'b1;
    @(posedge top_clk);
    #1;
    run_frame(TARGET, 0, d);
    chk("t1_restart_done", d, 1);

    // No consumes: four lines accepted, then one consume admits one more line.
    do_reset();
    start = 1; cycle(); start = 0;
    acc_total = 0;
    in_data_valid = 1;
    for (int i = 0; i < 60; i++) begin
      in_data = 8'($urandom);
      cycle();
      if (acc_seen) acc_total++;
    end
    chk("t3_first_fill", acc_total, W * LB);
    lb_line_consumed = 1; cycle(); lb_line_consumed = 0;
    if (acc_seen) acc_total++;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (acc_seen) acc_total++;
    end
    chk("t3_after_consume", acc_total, W * LB + W);

    // Watermark stall at column 3: no loss or duplication on the forwarded stream.
    do_reset();
    start = 1; cycle(); start = 0;
    acc_total = 0; stalls = 0; next_pix = 0;
    lbq.delete();
    for (int i = 0; i < 24; i++) begin
      in_data_valid  = 1;
      in_data        = 8'(next_pix);
      fifo_prog_full = (acc_total == 3) && (stalls < 5);
      if (fifo_prog_full) stalls++;
      cycle();
      if (fifo_prog_full) chk("t4_stall_no_accept", acc_seen, 0);
      if (acc_seen) begin acc_total++; next_pix++; end
      if (lbv_seen) lbq.push_back(lbd_seen);
    end
    clear_inputs();
    cycle();
    if (lbv_seen) lbq.push_back(lbd_seen);
    chk("t4_stream_len", lbq.size(), acc_total);
    for (int i = 0; i < lbq.size(); i++) chk($sformatf("t4_pix%0d", i), lbq[i], i);

    // Consume coinciding with a line wrap at two buffered lines leaves credit unchanged.
    do_reset();
    start = 1; cycle(); start = 0;
    acc_total = 0;
    for (int i = 0; i < 80; i++) begin
      in_data_valid    = 1;
      in_data          = 8'($urandom);
      lb_line_consumed = (acc_total == 3 * W - 1);
      cycle();
      if (acc_seen) acc_total++;
    end
    clear_inputs();
    chk("t5_accepted", acc_total, W * LB + W);

    // Consume with nothing buffered raises a sticky error.
    do_reset();
    chk("t5_err_clear", err_underflow, 0);
    lb_line_consumed = 1; cycle(); lb_line_consumed = 0;
    chk("t5_err_set", err_underflow, 1);
    repeat (5) cycle();
    chk("t5_err_sticky", err_underflow, 1);

    // Abort in DRAIN with ten outputs counted, stray outputs ignored, then a full frame.
    do_reset();
    run_frame(10, 1, d);
    chk("t6_no_done", d, 0);
    chk("t6_busy", busy, 0);
    chk("t6_row", row_count, 0);
    conv_data_valid = 1;
    repeat (5) cycle();
    conv_data_valid = 0;
    run_frame(TARGET, 0, d);
    chk("t6_new_frame_done", d, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start            = ($urandom_range(0, 19) == 0);
      abort            = ($urandom_range(0, 199) == 0);
      in_data_valid    = ($urandom_range(0, 9) < 7);
      in_data          = 8'($urandom);
      lb_line_consumed = ($urandom_range(0, 9) == 0);
      fifo_prog_full   = ($urandom_range(0, 6) == 0);
      conv_data_valid  = ($urandom_range(0, 9) < 3);
      cycle();
    end
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
